alu_issue_queue: RTL and testbench
==================================

# alu_issue_queue

Parametrised ALU reservation station that replaces the fixed four-entry ALU station. It holds DEPTH dispatched ALU micro-ops, wakes waiting operands from the common data bus, and selects one ready entry per cycle in oldest-first order. The selected entry goes through a registered valid/ready issue port to the ALU. It sits between the dispatch/rename stage and the ALU functional unit, and a synchronous flush clears it on mispredict.

## Interface
- WIDTH, 32: operand data width in bits
- ROB_W, 3: ROB tag width in bits
- CTRL_W, 4: ALU control field width in bits
- DEPTH, 4: number of entries, ≥2
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of all entries and the issue register
- disp_valid  in  1  dispatch request
- disp_ready  out  1  at least one free entry
- disp_rdy1, disp_rdy2  in  1 each  operand already valid
- disp_val1, disp_val2  in  WIDTH each  operand value, used when rdy=1
- disp_tag1, disp_tag2  in  ROB_W each  producer ROB tag, used when rdy=0
- disp_ctrl  in  CTRL_W  ALU control
- disp_rob  in  ROB_W  destination ROB tag
- cdb_valid  in  1  broadcast valid
- cdb_tag  in  ROB_W  broadcast ROB tag
- cdb_value  in  WIDTH  broadcast result
- issue_valid  out  1  issue register holds an op
- issue_ready  in  1  ALU accepts the op
- issue_src1, issue_src2  out  WIDTH each  operands
- issue_ctrl  out  CTRL_W  ALU control
- issue_rob  out  ROB_W  destination tag
- occupancy  out  $clog2(DEPTH+1)  valid entry count; excludes the issue register

## Operation
- Entry state: valid, rdy1/2, val1/2, tag1/2, ctrl, rob.
- **Allocate.** When disp_valid && disp_ready, write the lowest-index free entry.
- **Dispatch bypass.** For a dispatched operand with rdy=0, if cdb_valid and cdb_tag==tag, store it ready with cdb_value.
- **Wakeup.** Every valid entry compares each non-ready operand tag against cdb_tag when cdb_valid. On a match, capture cdb_value and set rdy.
- **Request.** An entry requests when valid && rdy1 && rdy2, using registered state only. An operand woken this cycle requests next cycle.
- **Select.** When the issue register is empty or issue_ready=1, select one requesting entry (policy set under Configuration). Load it into the issue register and free the entry on the same edge.
- **Issue handshake.**
  - Transfer occurs when issue_valid && issue_ready.
  - issue_* stay stable while issue_valid && !issue_ready.
  - If no entry requests and the register drains, issue_valid falls.
- **disp_ready** is occupancy<DEPTH, computed from registered state. A same-cycle free does not raise it.
- **occupancy** next value = occupancy + alloc − select.
- **Flush.** Takes priority over dispatch, wakeup and select: all entries become invalid, issue_valid goes to 0, occupancy goes to 0.

## Timing
- **Reset values:** all entry valid=0, issue_valid=0, issue_src1/2=0, issue_ctrl=0, issue_rob=0, occupancy=0, disp_ready=1.
- **Minimum latency:** an op dispatched with both operands ready at edge N has issue_valid=1 after edge N+1.
- **Wakeup latency:** a CDB match at edge N, with the other operand ready, gives issue_valid after edge N+1.
- **Full:** disp_ready=0; a disp_valid asserted in that cycle is ignored and has no effect on state.
- **Simultaneous alloc and select:** occupancy is unchanged. The freed index is not reused in the same cycle.
- **Reset mid-operation:** state is cleared immediately, without waiting for the clock.
- **CDB tag match on both operands:** both operands capture cdb_value.

## Configuration
- **ALU_RS_AGE_SELECT_EN defined:** oldest-first selection via an age matrix.
  - Each allocated entry is marked younger than every currently valid entry.
  - Select the requesting entry with no requesting older entry.
- **Undefined:** fixed priority, where the lowest requesting index wins. The age matrix is not built.

## Structure
- Package alu_rs_pkg holds:
  - the rs_entry_t struct (valid, rdy1/2, val1/2, tag1/2, ctrl, rob), parameterised via the package defaults;
  - the CTRL_W and ROB_W defaults;
  - the oldest-select and lowest-index-select functions.
- Sub-module alu_rs_age_matrix (DEPTH×DEPTH flops):
  - inputs: alloc one-hot, free one-hot, request vector;
  - output: one-hot grant;
  - instantiated only under ALU_RS_AGE_SELECT_EN.

## Test plan
- Reset, then dispatch one op with rdy1=rdy2=1, val1=5, val2=7, ctrl=3, rob=2 → issue_valid=1 one edge later with src1=5, src2=7, ctrl=3, rob=2; occupancy returns to 0.
- Dispatch an op with rdy1=0, tag1=4; two cycles later drive cdb_valid, cdb_tag=4, cdb_value=0x55 → issue_src1=0x55 two edges after the CDB cycle.
- Fill DEPTH entries, all waiting, then attempt a 5th dispatch → disp_ready=0, occupancy=DEPTH, the 5th op never issues.
- With the macro defined: dispatch A into index 2 and B into index 0 (B younger), wake both on one CDB tag → A issues before B. Without the macro → B issues first.
- Hold issue_ready=0 with 2 ready entries → issue_* stable for 3 cycles, occupancy=1. Raise issue_ready → the second op issues next edge.
- Assert flush with 3 entries valid and issue_valid=1 → next edge issue_valid=0, occupancy=0, disp_ready=1.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared types, width defaults and selection helpers for the ALU
// reservation station (alu_issue_queue) and its optional age matrix.
//
// Contents:
//   WIDTH_DEFAULT / ROB_W_DEFAULT / CTRL_W_DEFAULT : default field widths
//   MAX_DEPTH     : largest station depth the select helpers handle
//   rs_entry_t    : one station entry at the default widths
//   rs_vec_t      : request/grant vector, MAX_DEPTH bits
//   rs_mat_t      : age matrix, row i bit j set = entry j older than entry i
//   lowest_select : one-hot grant of the lowest-index request
//   oldest_select : one-hot grant of the request with no older requester
package alu_rs_pkg;

  localparam int WIDTH_DEFAULT  = 32;
  localparam int ROB_W_DEFAULT  = 3;
  localparam int CTRL_W_DEFAULT = 4;
  localparam int MAX_DEPTH      = 16;

  typedef struct packed {
    logic                      valid;
    logic                      rdy1;
    logic                      rdy2;
    logic [WIDTH_DEFAULT-1:0]  val1;
    logic [WIDTH_DEFAULT-1:0]  val2;
    logic [ROB_W_DEFAULT-1:0]  tag1;
    logic [ROB_W_DEFAULT-1:0]  tag2;
    logic [CTRL_W_DEFAULT-1:0] ctrl;
    logic [ROB_W_DEFAULT-1:0]  rob;
  } rs_entry_t;

  typedef logic [MAX_DEPTH-1:0]                rs_vec_t;
  typedef logic [MAX_DEPTH-1:0][MAX_DEPTH-1:0] rs_mat_t;

  function automatic rs_vec_t lowest_select(input rs_vec_t req);
    rs_vec_t g;
    g = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (req[i] && (g == '0)) g[i] = 1'b1;
    end
    return g;
  endfunction

  // Valid entries form a total order, so exactly one requester has no
  // requesting entry older than itself.
  function automatic rs_vec_t oldest_select(input rs_vec_t req, input rs_mat_t older);
    rs_vec_t g;
    g = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      g[i] = req[i] && ((older[i] & req) == '0);
    end
    return g;
  endfunction

endpackage

// File: rtl/alu_rs_age_matrix.sv
// alu_rs_age_matrix: DEPTH x DEPTH age matrix giving oldest-first grant.
// Only instantiated when ALU_RS_AGE_SELECT_EN is defined.
//
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   alloc_oh     : one-hot entry being allocated this cycle (or zero)
//   free_oh      : one-hot entry being freed this cycle (or zero)
//   req          : entries requesting issue
//   grant        : one-hot oldest requesting entry (zero if no request)
//
// Row i bit j set means entry j is older than entry i. An allocated row is
// set to "everyone else is older"; its column is cleared so no other entry
// treats it as older. Bits pointing at invalid entries are harmless since
// invalid entries never request, and they are rewritten on reallocation.
module alu_rs_age_matrix
  import alu_rs_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DEPTH-1:0] alloc_oh,
  input  logic [DEPTH-1:0] free_oh,
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] grant
);

  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];
  rs_mat_t          older_m;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_oh[i]) older_d[i] = ~alloc_oh & ~free_oh;
      else             older_d[i] = older_q[i] & ~alloc_oh & ~free_oh;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) older_q[i] <= older_d[i];
    end
  end

  always_comb begin
    older_m = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) older_m[i][j] = older_q[i][j];
    end
    grant = DEPTH'(oldest_select(rs_vec_t'(req), older_m));
  end

endmodule

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: DEPTH-entry ALU reservation station with CDB wakeup,
// one-per-cycle select and a registered valid/ready issue port.
//
// Optional feature macro: ALU_RS_AGE_SELECT_EN
//   defined   -> oldest-first select through alu_rs_age_matrix
//   undefined -> lowest requesting index wins
//
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   flush                      : synchronous clear of entries and issue reg
//   disp_valid / disp_ready    : dispatch handshake (ready = free entry)
//   disp_rdy*/val*/tag*        : operand state at dispatch
//   disp_ctrl, disp_rob        : ALU control, destination ROB tag
//   cdb_valid/tag/value        : result broadcast for wakeup
//   issue_valid / issue_ready  : issue handshake toward the ALU
//   issue_src1/2, ctrl, rob    : issued op
//   occupancy                  : valid entries, issue register excluded
// DEPTH must not exceed alu_rs_pkg::MAX_DEPTH.
module alu_issue_queue
  import alu_rs_pkg::*;
#(
  parameter  int WIDTH  = alu_rs_pkg::WIDTH_DEFAULT,
  parameter  int ROB_W  = alu_rs_pkg::ROB_W_DEFAULT,
  parameter  int CTRL_W = alu_rs_pkg::CTRL_W_DEFAULT,
  parameter  int DEPTH  = 4,
  localparam int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic              disp_rdy1,
  input  logic              disp_rdy2,
  input  logic [WIDTH-1:0]  disp_val1,
  input  logic [WIDTH-1:0]  disp_val2,
  input  logic [ROB_W-1:0]  disp_tag1,
  input  logic [ROB_W-1:0]  disp_tag2,
  input  logic [CTRL_W-1:0] disp_ctrl,
  input  logic [ROB_W-1:0]  disp_rob,
  input  logic              cdb_valid,
  input  logic [ROB_W-1:0]  cdb_tag,
  input  logic [WIDTH-1:0]  cdb_value,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [WIDTH-1:0]  issue_src1,
  output logic [WIDTH-1:0]  issue_src2,
  output logic [CTRL_W-1:0] issue_ctrl,
  output logic [ROB_W-1:0]  issue_rob,
  output logic [OCC_W-1:0]  occupancy
);

  typedef struct packed {
    logic              valid;
    logic              rdy1;
    logic              rdy2;
    logic [WIDTH-1:0]  val1;
    logic [WIDTH-1:0]  val2;
    logic [ROB_W-1:0]  tag1;
    logic [ROB_W-1:0]  tag2;
    logic [CTRL_W-1:0] ctrl;
    logic [ROB_W-1:0]  rob;
  } entry_t;

  entry_t ent_q [DEPTH];
  entry_t ent_d [DEPTH];
  entry_t new_ent;

  logic              iss_valid_q, iss_valid_d;
  logic [WIDTH-1:0]  iss_src1_q, iss_src1_d;
  logic [WIDTH-1:0]  iss_src2_q, iss_src2_d;
  logic [CTRL_W-1:0] iss_ctrl_q, iss_ctrl_d;
  logic [ROB_W-1:0]  iss_rob_q, iss_rob_d;
  logic [OCC_W-1:0]  occ_q, occ_d;

  logic [DEPTH-1:0]  valid_vec, req, grant, alloc_oh;
  logic              can_select, do_select, do_alloc;
  logic [WIDTH-1:0]  sel_val1, sel_val2;
  logic [CTRL_W-1:0] sel_ctrl;
  logic [ROB_W-1:0]  sel_rob;

  // Requests come from registered state only: an operand woken this cycle
  // requests next cycle.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_req
    assign valid_vec[gi] = ent_q[gi].valid;
    assign req[gi]       = ent_q[gi].valid & ent_q[gi].rdy1 & ent_q[gi].rdy2;
  end

  assign disp_ready = (occ_q < OCC_W'(DEPTH));
  assign can_select = !iss_valid_q || issue_ready;
  assign do_select  = can_select && (|req) && !flush;
  assign do_alloc   = disp_valid && disp_ready && !flush;
  // Free slots come from registered valid bits, so a slot freed by this
  // cycle's select is not reused until the next cycle.
  assign alloc_oh   = do_alloc ? DEPTH'(lowest_select(rs_vec_t'(~valid_vec))) : '0;

`ifdef ALU_RS_AGE_SELECT_EN
  alu_rs_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk      (clk),
    .reset    (reset),
    .alloc_oh (alloc_oh),
    .free_oh  (do_select ? grant : '0),
    .req      (req),
    .grant    (grant)
  );
`else
  assign grant = DEPTH'(lowest_select(rs_vec_t'(req)));
`endif

  always_comb begin
    sel_val1 = '0;
    sel_val2 = '0;
    sel_ctrl = '0;
    sel_rob  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        sel_val1 = ent_q[i].val1;
        sel_val2 = ent_q[i].val2;
        sel_ctrl = ent_q[i].ctrl;
        sel_rob  = ent_q[i].rob;
      end
    end
  end

  // Incoming entry with same-cycle CDB bypass for not-yet-ready operands.
  always_comb begin
    new_ent       = '0;
    new_ent.valid = 1'b1;
    new_ent.tag1  = disp_tag1;
    new_ent.tag2  = disp_tag2;
    new_ent.ctrl  = disp_ctrl;
    new_ent.rob   = disp_rob;
    if (disp_rdy1) begin
      new_ent.rdy1 = 1'b1;
      new_ent.val1 = disp_val1;
    end else if (cdb_valid && (cdb_tag == disp_tag1)) begin
      new_ent.rdy1 = 1'b1;
      new_ent.val1 = cdb_value;
    end
    if (disp_rdy2) begin
      new_ent.rdy2 = 1'b1;
      new_ent.val2 = disp_val2;
    end else if (cdb_valid && (cdb_tag == disp_tag2)) begin
      new_ent.rdy2 = 1'b1;
      new_ent.val2 = cdb_value;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (cdb_valid && ent_q[i].valid) begin
        if (!ent_q[i].rdy1 && (ent_q[i].tag1 == cdb_tag)) begin
          ent_d[i].rdy1 = 1'b1;
          ent_d[i].val1 = cdb_value;
        end
        if (!ent_q[i].rdy2 && (ent_q[i].tag2 == cdb_tag)) begin
          ent_d[i].rdy2 = 1'b1;
          ent_d[i].val2 = cdb_value;
        end
      end
      if (do_select && grant[i]) ent_d[i].valid = 1'b0;
      if (alloc_oh[i])           ent_d[i] = new_ent;
      if (flush)                 ent_d[i].valid = 1'b0;
    end
  end

  // The issue register only reloads when empty or draining, which keeps
  // issue_* stable while the ALU stalls.
  always_comb begin
    iss_valid_d = iss_valid_q;
    iss_src1_d  = iss_src1_q;
    iss_src2_d  = iss_src2_q;
    iss_ctrl_d  = iss_ctrl_q;
    iss_rob_d   = iss_rob_q;
    if (flush) begin
      iss_valid_d = 1'b0;
    end else if (can_select) begin
      iss_valid_d = |req;
      if (|req) begin
        iss_src1_d = sel_val1;
        iss_src2_d = sel_val2;
        iss_ctrl_d = sel_ctrl;
        iss_rob_d  = sel_rob;
      end
    end
    if (flush) occ_d = '0;
    else       occ_d = occ_q + OCC_W'(do_alloc) - OCC_W'(do_select);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      iss_valid_q <= 1'b0;
      iss_src1_q  <= '0;
      iss_src2_q  <= '0;
      iss_ctrl_q  <= '0;
      iss_rob_q   <= '0;
      occ_q       <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      iss_valid_q <= iss_valid_d;
      iss_src1_q  <= iss_src1_d;
      iss_src2_q  <= iss_src2_d;
      iss_ctrl_q  <= iss_ctrl_d;
      iss_rob_q   <= iss_rob_d;
      occ_q       <= occ_d;
    end
  end

  assign issue_valid = iss_valid_q;
  assign issue_src1  = iss_src1_q;
  assign issue_src2  = iss_src2_q;
  assign issue_ctrl  = iss_ctrl_q;
  assign issue_rob   = iss_rob_q;
  assign occupancy   = occ_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: directed scenarios plus randomized traffic, compared
// each cycle against a behavioural model of the reservation station.
module tb_alu_issue_queue;

  localparam int WIDTH = 32, ROB_W = 3, CTRL_W = 4, DEPTH = 4;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic reset, flush, disp_valid, disp_ready, disp_rdy1, disp_rdy2;
  logic [WIDTH-1:0]  disp_val1, disp_val2, cdb_value, issue_src1, issue_src2;
  logic [ROB_W-1:0]  disp_tag1, disp_tag2, disp_rob, cdb_tag, issue_rob;
  logic [CTRL_W-1:0] disp_ctrl, issue_ctrl;
  logic cdb_valid, issue_valid, issue_ready;
  logic [OCC_W-1:0]  occupancy;

  always #5 clk = ~clk;

  alu_issue_queue #(.WIDTH(WIDTH), .ROB_W(ROB_W), .CTRL_W(CTRL_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_rdy1(disp_rdy1), .disp_rdy2(disp_rdy2),
    .disp_val1(disp_val1), .disp_val2(disp_val2),
    .disp_tag1(disp_tag1), .disp_tag2(disp_tag2),
    .disp_ctrl(disp_ctrl), .disp_rob(disp_rob),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_src1(issue_src1), .issue_src2(issue_src2),
    .issue_ctrl(issue_ctrl), .issue_rob(issue_rob),
    .occupancy(occupancy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Behavioural model: a slot table plus an allocation sequence number
  // standing in for age.
  logic              m_v [DEPTH], m_r1 [DEPTH], m_r2 [DEPTH];
  logic [WIDTH-1:0]  m_a [DEPTH], m_b [DEPTH];
  logic [ROB_W-1:0]  m_t1 [DEPTH], m_t2 [DEPTH], m_rob [DEPTH];
  logic [CTRL_W-1:0] m_ctrl [DEPTH];
  int                m_age [DEPTH];
  int                m_seq, m_occ;
  logic              mi_v;
  logic [WIDTH-1:0]  mi_a, mi_b;
  logic [CTRL_W-1:0] mi_ctrl;
  logic [ROB_W-1:0]  mi_rob;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
    mi_v = 1'b0; mi_a = '0; mi_b = '0; mi_ctrl = '0; mi_rob = '0;
    m_occ = 0; m_seq = 0;
  endtask

  task automatic model_step();
    int pick, ai;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
      mi_v = 1'b0; m_occ = 0;
      return;
    end
    pick = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_v[i] && m_r1[i] && m_r2[i]) begin
`ifdef ALU_RS_AGE_SELECT_EN
        if (pick < 0 || m_age[i] < m_age[pick]) pick = i;
`else
        if (pick < 0) pick = i;
`endif
      end
    end
    ai = -1;
    if (disp_valid && m_occ < DEPTH)
      for (int i = 0; i < DEPTH; i++) if (!m_v[i] && ai < 0) ai = i;
    if (!mi_v || issue_ready) begin
      mi_v = (pick >= 0);
      if (pick >= 0) begin
        mi_a = m_a[pick]; mi_b = m_b[pick]; mi_ctrl = m_ctrl[pick]; mi_rob = m_rob[pick];
        m_v[pick] = 1'b0;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (m_v[i] && cdb_valid) begin
        if (!m_r1[i] && m_t1[i] == cdb_tag) begin m_r1[i] = 1'b1; m_a[i] = cdb_value; end
        if (!m_r2[i] && m_t2[i] == cdb_tag) begin m_r2[i] = 1'b1; m_b[i] = cdb_value; end
      end
    end
    if (ai >= 0) begin
      m_v[ai] = 1'b1; m_t1[ai] = disp_tag1; m_t2[ai] = disp_tag2;
      m_ctrl[ai] = disp_ctrl; m_rob[ai] = disp_rob;
      m_r1[ai] = disp_rdy1 || (cdb_valid && cdb_tag == disp_tag1);
      m_a[ai]  = disp_rdy1 ? disp_val1 : cdb_value;
      m_r2[ai] = disp_rdy2 || (cdb_valid && cdb_tag == disp_tag2);
      m_b[ai]  = disp_rdy2 ? disp_val2 : cdb_value;
      m_age[ai] = m_seq; m_seq++;
    end
    m_occ = 0;
    for (int i = 0; i < DEPTH; i++) if (m_v[i]) m_occ++;
  endtask

  task automatic compare_model();
    check("issue_valid", issue_valid, mi_v);
    check("occupancy", occupancy, m_occ);
    check("disp_ready", disp_ready, m_occ < DEPTH);
    if (mi_v) begin
      check("issue_src1", issue_src1, mi_a);
      check("issue_src2", issue_src2, mi_b);
      check("issue_ctrl", issue_ctrl, mi_ctrl);
      check("issue_rob", issue_rob, mi_rob);
    end
  endtask

  // One clock: model advances on the inputs currently driven, then the DUT
  // is sampled 1 time unit after the edge.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic idle();
    disp_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic drive_disp(input logic r1, input logic r2, input logic [WIDTH-1:0] v1,
                            input logic [WIDTH-1:0] v2, input logic [ROB_W-1:0] t1,
                            input logic [ROB_W-1:0] t2, input logic [CTRL_W-1:0] c,
                            input logic [ROB_W-1:0] rob);
    disp_valid = 1'b1; disp_rdy1 = r1; disp_rdy2 = r2;
    disp_val1 = v1; disp_val2 = v2; disp_tag1 = t1; disp_tag2 = t2;
    disp_ctrl = c; disp_rob = rob;
  endtask

  task automatic drive_cdb(input logic [ROB_W-1:0] t, input logic [WIDTH-1:0] v);
    cdb_valid = 1'b1; cdb_tag = t; cdb_value = v;
  endtask

  int issued;
  logic [ROB_W-1:0] first_rob, second_rob;

  initial begin
    reset = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_rdy1 = 1'b0; disp_rdy2 = 1'b0;
    disp_val1 = '0; disp_val2 = '0; disp_tag1 = '0; disp_tag2 = '0; disp_ctrl = '0;
    disp_rob = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; issue_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_issue_valid", issue_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_disp_ready", disp_ready, 1);
    check("rst_src1", issue_src1, 0);
    check("rst_src2", issue_src2, 0);
    check("rst_ctrl", issue_ctrl, 0);
    check("rst_rob", issue_rob, 0);
    reset = 1'b0;

    // Ready-at-dispatch op: one edge to the station, one to the issue reg.
    drive_disp(1, 1, 5, 7, 0, 0, 3, 2);
    step();
    check("lat_occ_after_disp", occupancy, 1);
    check("lat_not_yet_valid", issue_valid, 0);
    idle();
    step();
    check("lat_issue_valid", issue_valid, 1);
    check("lat_src1", issue_src1, 5);
    check("lat_src2", issue_src2, 7);
    check("lat_ctrl", issue_ctrl, 3);
    check("lat_rob", issue_rob, 2);
    check("lat_occ_zero", occupancy, 0);
    step();
    check("lat_drained", issue_valid, 0);

    // Wakeup through the CDB.
    drive_disp(0, 1, 0, 9, 4, 0, 1, 1);
    step();
    idle();
    step(); step();
    drive_cdb(4, 32'h55);
    step();
    idle();
    step();
    check("wake_issue_valid", issue_valid, 1);
    check("wake_src1", issue_src1, 32'h55);
    step();

    // Fill the station with waiting ops, then try one more.
    for (int i = 0; i < DEPTH; i++) begin
      drive_disp(0, 1, 0, i, 6, 0, 2, ROB_W'(i));
      step();
    end
    check("full_occ", occupancy, DEPTH);
    check("full_disp_ready", disp_ready, 0);
    drive_disp(1, 1, 11, 12, 0, 0, 5, 7);
    step();
    check("full_occ_ignored", occupancy, DEPTH);
    idle();
    drive_cdb(6, 32'hA6);
    step();
    idle();
    issued = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (issue_valid) begin
        issued++;
        check("full_5th_never_issues", issue_rob == 7, 0);
      end
    end
    check("full_issued_count", issued, DEPTH);

    // Age order: A lands in slot 2, B later in slot 0.
    drive_disp(0, 1, 0, 1, 6, 0, 0, 0); step();
    drive_disp(0, 1, 0, 1, 6, 0, 0, 1); step();
    drive_disp(0, 1, 0, 2, 5, 0, 0, 2); step();
    idle(); drive_cdb(6, 32'h66); step();
    idle(); repeat (4) step();
    drive_disp(0, 1, 0, 3, 5, 0, 0, 3); step();
    idle(); drive_cdb(5, 32'h77); step();
    idle();
`ifdef ALU_RS_AGE_SELECT_EN
    first_rob = 3'd2; second_rob = 3'd3;
`else
    first_rob = 3'd3; second_rob = 3'd2;
`endif
    step();
    check("age_first_valid", issue_valid, 1);
    check("age_first_rob", issue_rob, first_rob);
    step();
    check("age_second_rob", issue_rob, second_rob);
    check("age_woken_src1", issue_src1, 32'h77);
    step();

    // Back-pressure: issue_* hold while the ALU stalls.
    issue_ready = 1'b0;
    drive_disp(1, 1, 32'h40, 32'h41, 0, 0, 4, 4); step();
    drive_disp(1, 1, 32'h50, 32'h51, 0, 0, 5, 5); step();
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_rob", issue_rob, 4);
      check("stall_src1", issue_src1, 32'h40);
      check("stall_occ", occupancy, 1);
    end
    issue_ready = 1'b1;
    step();
    check("stall_next_rob", issue_rob, 5);
    check("stall_next_src2", issue_src2, 32'h51);
    step();
    check("stall_drained", issue_valid, 0);

    // Flush with a held issue op and three waiting entries.
    issue_ready = 1'b0;
    drive_disp(1, 1, 1, 2, 0, 0, 6, 6); step();
    for (int i = 1; i <= 3; i++) begin
      drive_disp(0, 0, 0, 0, 7, 7, 1, ROB_W'(i)); step();
    end
    check("flush_pre_valid", issue_valid, 1);
    check("flush_pre_occ", occupancy, 3);
    flush = 1'b1;
    drive_disp(1, 1, 9, 9, 0, 0, 1, 1);
    step();
    check("flush_issue_valid", issue_valid, 0);
    check("flush_occ", occupancy, 0);
    check("flush_disp_ready", disp_ready, 1);
    idle();
    issue_ready = 1'b1;
    step();

    // Asynchronous reset in the middle of a cycle.
    issue_ready = 1'b0;
    drive_disp(1, 1, 3, 4, 0, 0, 2, 3); step();
    drive_disp(0, 1, 0, 4, 2, 0, 2, 4); step();
    idle();
    #2 reset = 1'b1;
    #1;
    check("arst_issue_valid", issue_valid, 0);
    check("arst_occ", occupancy, 0);
    check("arst_disp_ready", disp_ready, 1);
    #1 reset = 1'b0;
    model_reset();
    issue_ready = 1'b1;
    step();

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      disp_valid  = ($urandom_range(0, 9) < 6);
      disp_rdy1   = $urandom_range(0, 1) == 1;
      disp_rdy2   = $urandom_range(0, 1) == 1;
      disp_val1   = $urandom;
      disp_val2   = $urandom;
      disp_tag1   = ROB_W'($urandom_range(0, 7));
      disp_tag2   = ROB_W'($urandom_range(0, 7));
      disp_ctrl   = CTRL_W'($urandom_range(0, 15));
      disp_rob    = ROB_W'($urandom_range(0, 7));
      cdb_valid   = ($urandom_range(0, 9) < 4);
      cdb_tag     = ROB_W'($urandom_range(0, 7));
      cdb_value   = $urandom;
      issue_ready = ($urandom_range(0, 9) < 7);
      flush       = ($urandom_range(0, 99) < 2);
      step();
    end
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
